pong_engine: RTL and testbench

PONG_ENGINE -- requirements
Module: pong_engine

---
 rtl/pong_pkg.sv | 37 +++
 rtl/pong_if.sv | 37 +++
 rtl/pong_paddle.sv | 32 +++
 rtl/pong_engine.sv | 190 +++++++++++++++++++
 tb/tb_pong_engine.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared FSM/winner encodings, default geometry and a saturating helper
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2
    } winner_t;

    localparam int DEF_H_RES            = 640;
    localparam int DEF_V_RES            = 480;
    localparam int DEF_WALL             = 10;
    localparam int DEF_PADDLE_LEN       = 50;
    localparam int DEF_PADDLE_W         = 10;
    localparam int DEF_PADDLE1_X        = 39;
    localparam int DEF_PADDLE2_X        = 590;
    localparam int DEF_BALL_SIZE        = 10;
    localparam int DEF_PADDLE_VEL       = 8;
    localparam int DEF_BALL_VEL_MIN     = 2;
    localparam int DEF_BALL_VEL_MAX     = 8;
    localparam int DEF_HITS_PER_SPEEDUP = 4;
    localparam int DEF_WIN_SCORE        = 7;
    localparam int DEF_SCORE_W          = 4;
    localparam int DEF_SERVE_FRAMES     = 60;

    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] max);
        return (v >= max) ? max : v + 4'd1;
    endfunction

endpackage

// File: rtl/pong_if.sv
// pong_if: player/frame controls into the engine and game state out of it
interface pong_if
    import pong_pkg::*;
#(
    parameter int SCORE_W = DEF_SCORE_W
);
    logic               frame_tick;
    logic               start;
    logic               pause;
    logic               up1;
    logic               down1;
    logic               up2;
    logic               down2;
    logic [9:0]         ball_x;
    logic [9:0]         ball_y;
    logic [9:0]         paddle1_y;
    logic [9:0]         paddle2_y;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic               miss1;
    logic               miss2;
    logic [1:0]         winner;
    logic [1:0]         state;
    logic [3:0]         ball_speed;

    modport master (
        output frame_tick, start, pause, up1, down1, up2, down2,
        input  ball_x, ball_y, paddle1_y, paddle2_y, score1, score2,
        input  miss1, miss2, winner, state, ball_speed
    );

    modport slave (
        input  frame_tick, start, pause, up1, down1, up2, down2,
        output ball_x, ball_y, paddle1_y, paddle2_y, score1, score2,
        output miss1, miss2, winner, state, ball_speed
    );
endinterface

// File: rtl/pong_paddle.sv
// pong_paddle: one paddle's vertical position, stepped per tick and clamped inside the walls
module pong_paddle
    import pong_pkg::*;
#(
    parameter int V_RES      = DEF_V_RES,
    parameter int WALL       = DEF_WALL,
    parameter int PADDLE_LEN = DEF_PADDLE_LEN,
    parameter int PADDLE_VEL = DEF_PADDLE_VEL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       center,
    input  logic       tick,
    input  logic       up,
    input  logic       down,
    output logic [9:0] y
);
    localparam logic [9:0] Y_MID = 10'((V_RES - PADDLE_LEN) / 2);
    localparam logic [9:0] Y_MIN = 10'(WALL);
    localparam logic [9:0] Y_MAX = 10'(V_RES - WALL - PADDLE_LEN);
    localparam logic [9:0] VEL   = 10'(PADDLE_VEL);

    // conflicting or absent commands hold; single commands step and saturate at the walls
    always_ff @(posedge clk) begin
        if (rst || center)
            y <= Y_MID;
        else if (tick && up && !down)
            y <= (y < Y_MIN + VEL) ? Y_MIN : y - VEL;
        else if (tick && down && !up)
            y <= (y + VEL > Y_MAX) ? Y_MAX : y + VEL;
    end
endmodule

// File: rtl/pong_engine.sv
// pong_engine: pong game FSM, ball physics, scoring and two paddles
module pong_engine
    import pong_pkg::*;
#(
    parameter int H_RES            = DEF_H_RES,
    parameter int V_RES            = DEF_V_RES,
    parameter int WALL             = DEF_WALL,
    parameter int PADDLE_LEN       = DEF_PADDLE_LEN,
    parameter int PADDLE_W         = DEF_PADDLE_W,
    parameter int PADDLE1_X        = DEF_PADDLE1_X,
    parameter int PADDLE2_X        = DEF_PADDLE2_X,
    parameter int BALL_SIZE        = DEF_BALL_SIZE,
    parameter int PADDLE_VEL       = DEF_PADDLE_VEL,
    parameter int BALL_VEL_MIN     = DEF_BALL_VEL_MIN,
    parameter int BALL_VEL_MAX     = DEF_BALL_VEL_MAX,
    parameter int HITS_PER_SPEEDUP = DEF_HITS_PER_SPEEDUP,
    parameter int WIN_SCORE        = DEF_WIN_SCORE,
    parameter int SCORE_W          = DEF_SCORE_W,
    parameter int SERVE_FRAMES     = DEF_SERVE_FRAMES
) (
    input logic   clk,
    input logic   rst,
    pong_if.slave bus
);
    localparam logic [9:0]         CX      = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [9:0]         CY      = 10'((V_RES - BALL_SIZE) / 2);
    localparam logic [9:0]         BS      = 10'(BALL_SIZE);
    localparam logic [9:0]         PL      = 10'(PADDLE_LEN);
    localparam logic [9:0]         P1_X    = 10'(PADDLE1_X);
    localparam logic [9:0]         P2_BACK = 10'(PADDLE2_X + PADDLE_W - BALL_SIZE);
    localparam logic signed [10:0] TOP     = 11'(WALL);
    localparam logic signed [10:0] BOT     = 11'(V_RES - WALL - BALL_SIZE);
    localparam logic signed [10:0] L_MISS  = 11'(WALL);
    localparam logic signed [10:0] R_MISS  = 11'(H_RES - WALL - BALL_SIZE);
    localparam logic signed [10:0] P1_FACE = 11'(PADDLE1_X + PADDLE_W);
    localparam logic signed [10:0] P2_FACE = 11'(PADDLE2_X - BALL_SIZE);
    localparam logic [3:0]         V_MIN   = 4'(BALL_VEL_MIN);
    localparam logic [3:0]         V_MAX   = 4'(BALL_VEL_MAX);
    localparam logic [7:0]         HPS     = 8'(HITS_PER_SPEEDUP - 1);
    localparam logic [15:0]        SF      = 16'(SERVE_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);

    state_t             st, st_n;
    winner_t            win, win_n;
    logic [9:0]         bx, by, bx_n, by_n, p1y, p2y;
    logic               xdir, ydir, xdir_n, ydir_n, serve_r, serve_n;
    logic [3:0]         spd, spd_n;
    logic [7:0]         hits, hits_n;
    logic [15:0]        scnt, scnt_n;
    logic [SCORE_W-1:0] s1, s2, s1_n, s2_n;
    logic               m1, m2, m1_n, m2_n;
    logic               go, ptick, hit1, hit2;
    logic signed [10:0] nx, ny;

    assign go    = bus.frame_tick && !bus.pause;
    assign ptick = go && (st == SERVE || st == PLAY);
    assign nx    = xdir ? $signed({1'b0, bx}) + $signed({7'd0, spd}) : $signed({1'b0, bx}) - $signed({7'd0, spd});
    assign ny    = ydir ? $signed({1'b0, by}) + $signed({7'd0, spd}) : $signed({1'b0, by}) - $signed({7'd0, spd});
    assign hit1  = !xdir && nx <= P1_FACE && bx > P1_X && by + BS > p1y && by < p1y + PL;
    assign hit2  = xdir && nx >= P2_FACE && bx < P2_BACK && by + BS > p2y && by < p2y + PL;

    pong_paddle #(.V_RES(V_RES), .WALL(WALL), .PADDLE_LEN(PADDLE_LEN), .PADDLE_VEL(PADDLE_VEL)) u_paddle1 (
        .clk(clk), .rst(rst), .center(st == IDLE), .tick(ptick), .up(bus.up1), .down(bus.down1), .y(p1y)
    );

    pong_paddle #(.V_RES(V_RES), .WALL(WALL), .PADDLE_LEN(PADDLE_LEN), .PADDLE_VEL(PADDLE_VEL)) u_paddle2 (
        .clk(clk), .rst(rst), .center(st == IDLE), .tick(ptick), .up(bus.up2), .down(bus.down2), .y(p2y)
    );

    // next-state and ball physics; a miss recentres the ball so OVER freezes it at center
    always_comb begin
        st_n = st;
        win_n = win;
        bx_n = bx;
        by_n = by;
        xdir_n = xdir;
        ydir_n = ydir;
        serve_n = serve_r;
        spd_n = spd;
        hits_n = hits;
        scnt_n = scnt;
        s1_n = s1;
        s2_n = s2;
        m1_n = 1'b0;
        m2_n = 1'b0;
        if (st == IDLE) begin
            st_n = bus.start ? SERVE : IDLE;
        end else if (st == SERVE) begin
            bx_n = CX;
            by_n = CY;
            xdir_n = serve_r;
            ydir_n = 1'b1;
            spd_n = V_MIN;
            hits_n = 8'd0;
            if (go) begin
                scnt_n = (scnt == SF) ? 16'd0 : scnt + 16'd1;
                st_n = (scnt == SF) ? PLAY : SERVE;
            end
        end else if (st == PLAY) begin
            if (go) begin
                if (ny <= TOP) begin
                    by_n = TOP[9:0];
                    ydir_n = 1'b1;
                end else if (ny >= BOT) begin
                    by_n = BOT[9:0];
                    ydir_n = 1'b0;
                end else begin
                    by_n = ny[9:0];
                end
                if (hit1 || hit2) begin
                    bx_n = hit1 ? P1_FACE[9:0] : P2_FACE[9:0];
                    xdir_n = hit1;
                    hits_n = (hits == HPS) ? 8'd0 : hits + 8'd1;
                    spd_n = (hits == HPS) ? sat_inc(spd, V_MAX) : spd;
                end else if (nx < L_MISS) begin
                    m1_n = 1'b1;
                    s2_n = s2 + 1'b1;
                    serve_n = 1'b0;
                    bx_n = CX;
                    by_n = CY;
                    st_n = (s2_n == WIN_S) ? OVER : SERVE;
                    win_n = (s2_n == WIN_S) ? WIN_P2 : WIN_NONE;
                end else if (nx > R_MISS) begin
                    m2_n = 1'b1;
                    s1_n = s1 + 1'b1;
                    serve_n = 1'b1;
                    bx_n = CX;
                    by_n = CY;
                    st_n = (s1_n == WIN_S) ? OVER : SERVE;
                    win_n = (s1_n == WIN_S) ? WIN_P1 : WIN_NONE;
                end else begin
                    bx_n = nx[9:0];
                end
            end
        end else if (bus.start) begin
            st_n = SERVE;
            s1_n = '0;
            s2_n = '0;
            win_n = WIN_NONE;
            serve_n = 1'b1;
        end
    end

    // game state registers; reset wins over any tick or start in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            win <= WIN_NONE;
            bx <= CX;
            by <= CY;
            xdir <= 1'b1;
            ydir <= 1'b1;
            serve_r <= 1'b1;
            spd <= V_MIN;
            hits <= 8'd0;
            scnt <= 16'd0;
            s1 <= '0;
            s2 <= '0;
            m1 <= 1'b0;
            m2 <= 1'b0;
        end else begin
            st <= st_n;
            win <= win_n;
            bx <= bx_n;
            by <= by_n;
            xdir <= xdir_n;
            ydir <= ydir_n;
            serve_r <= serve_n;
            spd <= spd_n;
            hits <= hits_n;
            scnt <= scnt_n;
            s1 <= s1_n;
            s2 <= s2_n;
            m1 <= m1_n;
            m2 <= m2_n;
        end
    end

    assign bus.ball_x     = bx;
    assign bus.ball_y     = by;
    assign bus.paddle1_y  = p1y;
    assign bus.paddle2_y  = p2y;
    assign bus.score1     = s1;
    assign bus.score2     = s2;
    assign bus.miss1      = m1;
    assign bus.miss2      = m2;
    assign bus.winner     = win;
    assign bus.state      = st;
    assign bus.ball_speed = spd;
endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: directed scenarios with hand-derived ball trajectories
module tb_pong_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pong_if bus ();

    pong_engine dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.frame_tick = 1'b1;
            @(negedge clk);
            bus.frame_tick = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
        n_tests++; if (bus.ball_x !== 10'd315 || bus.ball_y !== 10'd235) begin n_fail++; $display("FAIL reset_ball got=(%0d,%0d) exp=(315,235)", bus.ball_x, bus.ball_y); end
        n_tests++; if (bus.paddle1_y !== 10'd215 || bus.paddle2_y !== 10'd215) begin n_fail++; $display("FAIL reset_paddles got=(%0d,%0d) exp=(215,215)", bus.paddle1_y, bus.paddle2_y); end
        n_tests++; if (bus.score1 !== 4'd0 || bus.score2 !== 4'd0 || bus.winner !== 2'd0) begin n_fail++; $display("FAIL reset_score got=%0d/%0d w=%0d exp=0/0 w=0", bus.score1, bus.score2, bus.winner); end
        n_tests++; if (bus.ball_speed !== 4'd2 || bus.miss1 !== 1'b0 || bus.miss2 !== 1'b0) begin n_fail++; $display("FAIL reset_misc got=spd%0d m%0d%0d exp=spd2 m00", bus.ball_speed, bus.miss1, bus.miss2); end
    endtask

    task automatic test_idle();
        bus.up1 = 1'b1;
        ticks(3);
        bus.up1 = 1'b0;
        n_tests++; if (bus.state !== 2'd0 || bus.paddle1_y !== 10'd215 || bus.ball_x !== 10'd315) begin n_fail++; $display("FAIL idle_hold got=st%0d p1=%0d bx=%0d exp=st0 p1=215 bx=315", bus.state, bus.paddle1_y, bus.ball_x); end
    endtask

    task automatic test_serve_paddles();
        pulse_start();
        n_tests++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL start_serve got=%0d exp=1", bus.state); end
        bus.up1 = 1'b1;
        bus.down2 = 1'b1;
        ticks(30);
        bus.down2 = 1'b0;
        n_tests++; if (bus.paddle1_y !== 10'd10 || bus.paddle2_y !== 10'd420) begin n_fail++; $display("FAIL paddle_sat got=(%0d,%0d) exp=(10,420)", bus.paddle1_y, bus.paddle2_y); end
        n_tests++; if (bus.state !== 2'd1 || bus.ball_x !== 10'd315 || bus.ball_y !== 10'd235) begin n_fail++; $display("FAIL serve_hold got=st%0d (%0d,%0d) exp=st1 (315,235)", bus.state, bus.ball_x, bus.ball_y); end
        bus.down1 = 1'b1;
        ticks(2);
        n_tests++; if (bus.paddle1_y !== 10'd10) begin n_fail++; $display("FAIL paddle_both got=%0d exp=10", bus.paddle1_y); end
        bus.up1 = 1'b0;
        ticks(12);
        bus.down1 = 1'b0;
        n_tests++; if (bus.paddle1_y !== 10'd106) begin n_fail++; $display("FAIL paddle_down got=%0d exp=106", bus.paddle1_y); end
        bus.pause = 1'b1;
        ticks(5);
        bus.pause = 1'b0;
        ticks(15);
        n_tests++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL serve_59 got=%0d exp=1", bus.state); end
        ticks(1);
        n_tests++; if (bus.state !== 2'd2 || bus.ball_x !== 10'd315) begin n_fail++; $display("FAIL serve_60 got=st%0d bx=%0d exp=st2 bx=315", bus.state, bus.ball_x); end
    endtask

    task automatic test_play_hits();
        ticks(1);
        n_tests++; if (bus.ball_x !== 10'd317 || bus.ball_y !== 10'd237 || bus.ball_speed !== 4'd2) begin n_fail++; $display("FAIL first_play got=(%0d,%0d) spd%0d exp=(317,237) spd2", bus.ball_x, bus.ball_y, bus.ball_speed); end
        bus.pause = 1'b1;
        ticks(1);
        bus.pause = 1'b0;
        n_tests++; if (bus.ball_x !== 10'd317 || bus.ball_y !== 10'd237) begin n_fail++; $display("FAIL pause_play got=(%0d,%0d) exp=(317,237)", bus.ball_x, bus.ball_y); end
        ticks(131);
        n_tests++; if (bus.ball_x !== 10'd579 || bus.ball_y !== 10'd422) begin n_fail++; $display("FAIL pre_hit2 got=(%0d,%0d) exp=(579,422)", bus.ball_x, bus.ball_y); end
        ticks(1);
        n_tests++; if (bus.ball_x !== 10'd580 || bus.ball_y !== 10'd420) begin n_fail++; $display("FAIL hit2_a got=(%0d,%0d) exp=(580,420)", bus.ball_x, bus.ball_y); end
        ticks(265);
        n_tests++; if (bus.ball_x !== 10'd50 || bus.ball_y !== 10'd130) begin n_fail++; $display("FAIL pre_hit1 got=(%0d,%0d) exp=(50,130)", bus.ball_x, bus.ball_y); end
        ticks(1);
        n_tests++; if (bus.ball_x !== 10'd49 || bus.ball_y !== 10'd132 || bus.ball_speed !== 4'd2) begin n_fail++; $display("FAIL hit1_a got=(%0d,%0d) spd%0d exp=(49,132) spd2", bus.ball_x, bus.ball_y, bus.ball_speed); end
        bus.up2 = 1'b1;
        bus.down1 = 1'b1;
        ticks(20);
        bus.up2 = 1'b0;
        ticks(3);
        bus.down1 = 1'b0;
        n_tests++; if (bus.paddle1_y !== 10'd290 || bus.paddle2_y !== 10'd260) begin n_fail++; $display("FAIL play_paddles got=(%0d,%0d) exp=(290,260)", bus.paddle1_y, bus.paddle2_y); end
        ticks(242);
        n_tests++; if (bus.ball_x !== 10'd579 || bus.ball_y !== 10'd258) begin n_fail++; $display("FAIL pre_hit2_b got=(%0d,%0d) exp=(579,258)", bus.ball_x, bus.ball_y); end
        ticks(1);
        n_tests++; if (bus.ball_x !== 10'd580 || bus.ball_y !== 10'd256 || bus.ball_speed !== 4'd2) begin n_fail++; $display("FAIL hit2_b got=(%0d,%0d) spd%0d exp=(580,256) spd2", bus.ball_x, bus.ball_y, bus.ball_speed); end
        ticks(265);
        n_tests++; if (bus.ball_x !== 10'd50 || bus.ball_y !== 10'd294) begin n_fail++; $display("FAIL pre_hit1_b got=(%0d,%0d) exp=(50,294)", bus.ball_x, bus.ball_y); end
        ticks(1);
        n_tests++; if (bus.ball_x !== 10'd49 || bus.ball_y !== 10'd296 || bus.ball_speed !== 4'd3) begin n_fail++; $display("FAIL speedup got=(%0d,%0d) spd%0d exp=(49,296) spd3", bus.ball_x, bus.ball_y, bus.ball_speed); end
        ticks(1);
        n_tests++; if (bus.ball_x !== 10'd52 || bus.ball_y !== 10'd299) begin n_fail++; $display("FAIL speed3_move got=(%0d,%0d) exp=(52,299)", bus.ball_x, bus.ball_y); end
    endtask

    task automatic test_reset_mid_play();
        @(negedge clk);
        rst = 1'b1;
        bus.frame_tick = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.frame_tick = 1'b0;
        bus.start = 1'b0;
        n_tests++; if (bus.state !== 2'd0 || bus.ball_x !== 10'd315 || bus.ball_y !== 10'd235) begin n_fail++; $display("FAIL midplay_rst_ball got=st%0d (%0d,%0d) exp=st0 (315,235)", bus.state, bus.ball_x, bus.ball_y); end
        n_tests++; if (bus.paddle1_y !== 10'd215 || bus.paddle2_y !== 10'd215 || bus.ball_speed !== 4'd2) begin n_fail++; $display("FAIL midplay_rst_pad got=(%0d,%0d) spd%0d exp=(215,215) spd2", bus.paddle1_y, bus.paddle2_y, bus.ball_speed); end
    endtask

    task automatic test_miss();
        pulse_start();
        bus.down2 = 1'b1;
        ticks(26);
        bus.down2 = 1'b0;
        ticks(34);
        ticks(418);
        n_tests++; if (bus.ball_x !== 10'd10 || bus.state !== 2'd2) begin n_fail++; $display("FAIL pre_miss1 got=bx%0d st%0d exp=bx10 st2", bus.ball_x, bus.state); end
        ticks(1);
        n_tests++; if (bus.miss1 !== 1'b1 || bus.miss2 !== 1'b0) begin n_fail++; $display("FAIL miss1_pulse got=%0d%0d exp=10", bus.miss1, bus.miss2); end
        n_tests++; if (bus.score2 !== 4'd1 || bus.score1 !== 4'd0 || bus.state !== 2'd1) begin n_fail++; $display("FAIL miss1_score got=%0d/%0d st%0d exp=0/1 st1", bus.score1, bus.score2, bus.state); end
        @(negedge clk);
        n_tests++; if (bus.miss1 !== 1'b0) begin n_fail++; $display("FAIL miss1_width got=%0d exp=0", bus.miss1); end
        ticks(61);
        n_tests++; if (bus.ball_x !== 10'd313 || bus.ball_y !== 10'd237) begin n_fail++; $display("FAIL serve_left got=(%0d,%0d) exp=(313,237)", bus.ball_x, bus.ball_y); end
    endtask

    task automatic test_win();
        do_reset();
        pulse_start();
        for (int r = 1; r <= 7; r++) begin
            ticks(213);
            n_tests++; if (bus.score1 !== 4'(r) || bus.miss2 !== 1'b1 || bus.state !== ((r == 7) ? 2'd3 : 2'd1)) begin n_fail++; $display("FAIL rally_%0d got=s1=%0d m2=%0d st%0d exp=s1=%0d m2=1 st%0d", r, bus.score1, bus.miss2, bus.state, r, (r == 7) ? 3 : 1); end
        end
        n_tests++; if (bus.winner !== 2'd1 || bus.score2 !== 4'd0) begin n_fail++; $display("FAIL winner got=w%0d s2=%0d exp=w1 s2=0", bus.winner, bus.score2); end
        bus.pause = 1'b1;
        bus.up1 = 1'b1;
        ticks(5);
        bus.pause = 1'b0;
        ticks(3);
        bus.up1 = 1'b0;
        n_tests++; if (bus.state !== 2'd3 || bus.ball_x !== 10'd315 || bus.ball_y !== 10'd235 || bus.paddle1_y !== 10'd215 || bus.score1 !== 4'd7 || bus.winner !== 2'd1) begin n_fail++; $display("FAIL over_frozen got=st%0d (%0d,%0d) p1=%0d s1=%0d w%0d exp=st3 (315,235) p1=215 s1=7 w1", bus.state, bus.ball_x, bus.ball_y, bus.paddle1_y, bus.score1, bus.winner); end
        pulse_start();
        n_tests++; if (bus.state !== 2'd1 || bus.score1 !== 4'd0 || bus.score2 !== 4'd0 || bus.winner !== 2'd0) begin n_fail++; $display("FAIL restart got=st%0d %0d/%0d w%0d exp=st1 0/0 w0", bus.state, bus.score1, bus.score2, bus.winner); end
        ticks(61);
        n_tests++; if (bus.ball_x !== 10'd317 || bus.ball_y !== 10'd237) begin n_fail++; $display("FAIL restart_serve got=(%0d,%0d) exp=(317,237)", bus.ball_x, bus.ball_y); end
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.up1 = 1'b0;
        bus.down1 = 1'b0;
        bus.up2 = 1'b0;
        bus.down2 = 1'b0;
        test_reset();
        test_idle();
        test_serve_paddles();
        test_play_hits();
        test_reset_mid_play();
        test_miss();
        test_win();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
